ps2_rx_fifo: RTL and testbench

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

---
 rtl/ps2_rx_fifo.sv | 222 ++++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx_fifo
// Brief    : PS/2 device-to-host frame receiver feeding a FWFT receive FIFO
//            with sticky error flags and a level-based interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 2000,
    parameter int IRQ_THRESH     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    input  logic                          clear_int,
    output logic [7:0]                    rd_data,
    output logic                          data_rdy,
    output logic                          fifo_full,
    output logic                          valid,
    output logic                          interrupt,
    output logic                          parity_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int c_TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_TO_W-1:0]   c_TO_LAST  = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_ADDR_W:0]   c_FULL_LVL = (c_ADDR_W + 1)'(FIFO_DEPTH);
    localparam logic [c_ADDR_W:0]   c_IRQ_LVL  = (c_ADDR_W + 1)'(IRQ_THRESH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Line synchronizers and falling-edge detect on the PS/2 clock
    // ------------------------------------------------------------------
    logic [1:0] r_clk_sync;
    logic [1:0] r_data_sync;
    logic       r_clk_prev;
    logic       w_fall;
    logic       w_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_sync[1];
    assign w_bit  = r_data_sync[1];

    // ------------------------------------------------------------------
    // Frame receiver
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_next_state;
    logic [7:0]          r_shift;
    logic [2:0]          r_bit_cnt;
    logic                r_parity;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic                w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        if ((r_state != ST_IDLE) && !w_fall && (r_to_cnt == c_TO_LAST)) begin
            w_timeout    = 1'b1;
            w_next_state = ST_IDLE;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE:   if (!w_bit) w_next_state = ST_DATA;
                ST_DATA:   if (r_bit_cnt == 3'd7) w_next_state = ST_PARITY;
                ST_PARITY: w_next_state = ST_STOP;
                ST_STOP:   w_next_state = ST_IDLE;
                default:   w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= 8'h00;
            r_bit_cnt <= 3'd0;
            r_parity  <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            if ((r_state == ST_IDLE) || w_fall || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + c_TO_W'(1);
            end
            if (w_fall) begin
                case (r_state)
                    ST_IDLE:   r_bit_cnt <= 3'd0;
                    ST_DATA: begin
                        r_shift   <= {w_bit, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    ST_PARITY: r_parity <= w_bit;
                    default:   ;
                endcase
            end
        end
    end

    // The stop-bit edge is judged here, so a good frame lands in the FIFO
    // on the very clk edge that samples the stop bit.
    logic w_frame_end;
    logic w_frame_good;
    logic w_frame_bad;

    assign w_frame_end  = w_fall && (r_state == ST_STOP);
    assign w_frame_good = w_frame_end && w_bit && (^{r_parity, r_shift});
    assign w_frame_bad  = w_frame_end && !w_frame_good;

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_level;
    logic [c_ADDR_W:0]   w_level_nxt;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;

    assign w_full = (r_level == c_FULL_LVL);
    assign w_pop  = rd_en && (r_level != '0);
    assign w_push = w_frame_good && (!w_full || w_pop);
    assign w_drop = w_frame_good && w_full && !w_pop;

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + (c_ADDR_W + 1)'(1);
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - (c_ADDR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            r_level <= w_level_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Status flags; a set event outranks a same-cycle clear
    // ------------------------------------------------------------------
    logic r_valid;
    logic r_irq;
    logic r_perr;
    logic r_ovf;
    logic w_irq_set;

    assign w_irq_set = (w_push && (w_level_nxt >= c_IRQ_LVL)) || w_frame_bad || w_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_irq   <= 1'b0;
            r_perr  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_valid <= w_push;
            if (w_irq_set)        r_irq  <= 1'b1;
            else if (clear_int)   r_irq  <= 1'b0;
            if (w_frame_bad)      r_perr <= 1'b1;
            else if (clear_int)   r_perr <= 1'b0;
            if (w_drop)           r_ovf  <= 1'b1;
            else if (clear_int)   r_ovf  <= 1'b0;
        end
    end

    assign data_rdy   = (r_level != '0);
    assign fifo_full  = w_full;
    assign rd_data    = data_rdy ? r_mem[r_rd_ptr] : 8'h00;
    assign level      = r_level;
    assign valid      = r_valid;
    assign interrupt  = r_irq;
    assign parity_err = r_perr;
    assign overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_rx_fifo
// Brief    : Directed bench for ps2_rx_fifo with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_fifo;

    localparam int DEPTH = 8;
    localparam int TMO   = 200;
    localparam int THR   = 1;
    localparam int HALF  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic       clear_int = 1'b0;
    logic [7:0] rd_data;
    logic       data_rdy, fifo_full, valid, interrupt, parity_err, overflow;
    logic [3:0] level;

    int total = 0;
    int bad   = 0;
    int vcnt  = 0;

    ps2_rx_fifo #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .IRQ_THRESH     (THR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd_en      (rd_en),
        .clear_int  (clear_int),
        .rd_data    (rd_data),
        .data_rdy   (data_rdy),
        .fifo_full  (fifo_full),
        .valid      (valid),
        .interrupt  (interrupt),
        .parity_err (parity_err),
        .overflow   (overflow),
        .level      (level)
    );

    always #5 clk = ~clk;

    // Reference model: line values reach the receiver two clocks late, a
    // falling edge is seen one clock after that; frames are lists of 11 bits.
    logic [7:0] mq [$];
    bit         m_valid = 0, m_irq = 0, m_perr = 0, m_ovf = 0;
    bit         hc2 = 1, hc1 = 1, hc0 = 1, hd1 = 1, hd0 = 1;
    int         nb = 0, gap = 0;
    bit         mb [0:10];
    bit         f_fall, f_end, f_good, f_pop, f_push;
    logic [7:0] f_byte;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_valid = 0; m_irq = 0; m_perr = 0; m_ovf = 0;
            hc2 = 1; hc1 = 1; hc0 = 1; hd1 = 1; hd0 = 1;
            nb = 0; gap = 0;
        end else begin
            f_fall = hc2 && !hc1;
            f_end  = 0;
            f_good = 0;
            f_byte = 8'h00;
            if (f_fall) begin
                gap = 0;
                if (nb > 0 || hd1 == 1'b0) begin
                    mb[nb] = hd1;
                    nb++;
                end
                if (nb == 11) begin
                    f_end = 1;
                    for (int i = 0; i < 8; i++) f_byte[i] = mb[i+1];
                    f_good = mb[10] && ((^f_byte) ^ mb[9]);
                    nb = 0;
                end
            end else if (nb > 0) begin
                gap++;
                if (gap >= TMO) begin
                    nb  = 0;
                    gap = 0;
                end
            end
            hc2 = hc1; hc1 = hc0; hc0 = ps2_clk;
            hd1 = hd0; hd0 = ps2_data;

            f_pop  = rd_en && (mq.size() > 0);
            f_push = f_good && ((mq.size() < DEPTH) || f_pop);
            if (f_pop)  void'(mq.pop_front());
            if (f_push) mq.push_back(f_byte);
            m_valid = f_push;
            if ((f_push && mq.size() >= THR) || (f_end && !f_good) || (f_good && !f_push)) m_irq = 1;
            else if (clear_int) m_irq = 0;
            if (f_end && !f_good) m_perr = 1;
            else if (clear_int)   m_perr = 0;
            if (f_good && !f_push) m_ovf = 1;
            else if (clear_int)    m_ovf = 0;
        end
    end

    logic [17:0] got_v, exp_v;
    always begin
        @(posedge clk);
        #3;
        got_v = {rd_data, data_rdy, fifo_full, valid, interrupt, parity_err, overflow, level};
        exp_v = {(mq.size() > 0) ? mq[0] : 8'h00, mq.size() > 0, mq.size() == DEPTH,
                 m_valid, m_irq, m_perr, m_ovf, 4'(mq.size())};
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL cycle_compare t=%0t got=%05h expected=%05h", $time, got_v, exp_v);
        end
        if (valid === 1'b1) vcnt++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input bit b, input bit pop_on_fall);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF - 1) @(negedge clk);
        ps2_clk = 1'b0;
        if (pop_on_fall) begin
            repeat (2) @(negedge clk);
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            repeat (HALF - 3) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_bad, input bit pop_on_stop);
        bit p;
        p = par_bad ? (^d) : ~(^d);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
        send_bit(p, 1'b0);
        send_bit(1'b1, pop_on_stop);
        repeat (4) @(negedge clk);
    endtask

    task automatic pop();
        @(negedge clk); rd_en = 1'b1;
        @(negedge clk); rd_en = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear_int = 1'b1;
        @(negedge clk); clear_int = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_level", level, 0);
        chk("rst_rdy", data_rdy, 0);
        chk("rst_irq", interrupt, 0);
        chk("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single good frame
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("f1c_valid_count", vcnt, 1);
        chk("f1c_rd_data", rd_data, 8'h1C);
        chk("f1c_rdy", data_rdy, 1);
        chk("f1c_level", level, 1);
        chk("f1c_irq", interrupt, 1);
        pulse_clear();
        chk("f1c_irq_cleared", interrupt, 0);
        pop();
        chk("f1c_popped_level", level, 0);

        // Bad parity frame
        send_frame(8'hA5, 1'b1, 1'b0);
        chk("a5_level", level, 0);
        chk("a5_perr", parity_err, 1);
        chk("a5_irq", interrupt, 1);
        chk("a5_no_valid", vcnt, 1);
        pulse_clear();
        chk("a5_perr_cleared", parity_err, 0);

        // Overflow: nine frames into eight entries
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
        chk("ovf_full", fifo_full, 1);
        chk("ovf_flag", overflow, 1);
        chk("ovf_level", level, 8);
        chk("ovf_valid_count", vcnt, 9);
        for (int i = 1; i <= 8; i++) begin
            chk("ovf_drain", rd_data, i);
            pop();
        end
        chk("ovf_empty", data_rdy, 0);
        pulse_clear();

        // Partial frame aborted by timeout
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        repeat (TMO + 10) @(negedge clk);
        chk("tmo_perr", parity_err, 0);
        chk("tmo_ovf", overflow, 0);
        chk("tmo_irq", interrupt, 0);
        chk("tmo_level", level, 0);
        send_frame(8'h55, 1'b0, 1'b0);
        chk("tmo_next_frame", rd_data, 8'h55);
        pop();
        pulse_clear();

        // Full FIFO with pop aligned to the push
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0);
        chk("full_before", fifo_full, 1);
        send_frame(8'h77, 1'b0, 1'b1);
        chk("pp_level", level, 8);
        chk("pp_ovf", overflow, 0);
        chk("pp_full", fifo_full, 1);
        for (int i = 1; i < 8; i++) begin
            chk("pp_drain", rd_data, 8'h10 + i);
            pop();
        end
        chk("pp_last", rd_data, 8'h77);
        pop();
        chk("pp_empty", data_rdy, 0);
        pulse_clear();

        // Reset in the middle of a frame
        send_frame(8'h42, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mrst_level", level, 0);
        chk("mrst_rd_data", rd_data, 0);
        chk("mrst_rdy", data_rdy, 0);
        chk("mrst_irq", interrupt, 0);
        chk("mrst_valid", valid, 0);
        chk("mrst_full", fifo_full, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send_frame(8'h3A, 1'b0, 1'b0);
        chk("mrst_next_frame", rd_data, 8'h3A);
        chk("mrst_next_level", level, 1);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
